mt_fetch_stage: RTL

//  Barrel-processor fetch stage directly upstream of decode in mt_cpu. Holds one PC per hardware

---
 rtl/mt_cpu_pkg.sv | 20 ++
 rtl/mt_fetch_stage_thread_pc_file.sv | 44 ++++
 rtl/mt_fetch_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/mt_cpu_pkg.sv
// Shared types and constants for the mt_cpu barrel processor.
// Holds the thread-id width, the NOP encoding and the IF/ID latch struct.
package mt_cpu_pkg;

    localparam int ADDRESS_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF    = 32;
    localparam int NUM_THREADS_DEF   = 4;
    localparam int TID_W             = $clog2(NUM_THREADS_DEF);

    // addi x0, x0, 0
    localparam logic [DATA_WIDTH_DEF-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic                         valid;
        logic [TID_W-1:0]             tid;
        logic [ADDRESS_WIDTH_DEF-1:0] pc;
        logic [DATA_WIDTH_DEF-1:0]    instr;
    } if_id_t;

endpackage

// File: rtl/mt_fetch_stage_thread_pc_file.sv
// Per-thread PC registers: one combinational read port, one +4 write
// and one redirect write. The redirect wins over the increment for the same thread.
module thread_pc_file #(
    parameter int                  AW            = 32,
    parameter int                  NT            = 4,
    parameter int                  TW            = 2,
    parameter logic [AW-1:0]       RESET_PC      = '0,
    parameter int                  THREAD_STRIDE = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] rd_tid,
    output logic [AW-1:0] rd_pc,
    input  logic          inc_en,
    input  logic [TW-1:0] inc_tid,
    input  logic          redir_en,
    input  logic [TW-1:0] redir_tid,
    input  logic [AW-1:0] redir_pc
);

    logic [AW-1:0] pc_r [NT];

    assign rd_pc = pc_r[rd_tid];

    // PC update: a redirect sets the PC; if the same thread also fetched this cycle it fetched the redirect target, so step past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NT; t++) begin
                pc_r[t] <= RESET_PC + AW'(t * THREAD_STRIDE);
            end
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (redir_en && (redir_tid == TW'(t))) begin
                    pc_r[t] <= redir_pc + ((inc_en && (inc_tid == TW'(t))) ? AW'(4) : AW'(0));
                end else if (inc_en && (inc_tid == TW'(t))) begin
                    pc_r[t] <= pc_r[t] + AW'(4);
                end else begin
                    pc_r[t] <= pc_r[t];
                end
            end
        end
    end

endmodule

// File: rtl/mt_fetch_stage.sv
// Barrel-processor fetch stage: strict round-robin thread slots, IMEM read, IF/ID latch.
// Optional feature macro: MT_FETCH_THREAD_MASK_EN adds the thread_en input.
module mt_fetch_stage
    import mt_cpu_pkg::*;
#(
    parameter int                           ADDRESS_WIDTH = 32,
    parameter int                           DATA_WIDTH    = 32,
    parameter int                           NUM_THREADS   = 4,
    parameter logic [ADDRESS_WIDTH-1:0]     RESET_PC      = '0,
    parameter int                           THREAD_STRIDE = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           redir_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] redir_tid,
    input  logic [ADDRESS_WIDTH-1:0]       redir_pc,
`ifdef MT_FETCH_THREAD_MASK_EN
    input  logic [NUM_THREADS-1:0]         thread_en,
`endif
    output logic [ADDRESS_WIDTH-1:0]       imem_addr,
    input  logic [DATA_WIDTH-1:0]          imem_rdata,
    output logic                           if_valid,
    output logic [$clog2(NUM_THREADS)-1:0] if_tid,
    output logic [ADDRESS_WIDTH-1:0]       if_pc,
    output logic [DATA_WIDTH-1:0]          if_instr
);

    localparam int TW = $clog2(NUM_THREADS);

    logic [TW-1:0]            slot_r;
    logic [ADDRESS_WIDTH-1:0] pc_rd_s;
    logic [ADDRESS_WIDTH-1:0] redir_pc_s;
    logic                     redir_hit_s;
    logic                     fetch_en_s;
    logic                     inc_en_s;
    logic [NUM_THREADS-1:0]   thread_en_s;
    if_id_t                   if_id_r;

`ifdef MT_FETCH_THREAD_MASK_EN
    assign thread_en_s = thread_en;
`else
    assign thread_en_s = '1;
`endif

    assign redir_pc_s = {redir_pc[ADDRESS_WIDTH-1:2], 2'b00};

    // Slot address with same-cycle redirect bypass so the redirected thread loses no fetch.
    always_comb begin
        redir_hit_s = redir_valid && (redir_tid == slot_r);
        imem_addr   = redir_hit_s ? redir_pc_s : pc_rd_s;
        fetch_en_s  = thread_en_s[slot_r];
        inc_en_s    = (!stall) && fetch_en_s;
    end

    thread_pc_file #(
        .AW            (ADDRESS_WIDTH),
        .NT            (NUM_THREADS),
        .TW            (TW),
        .RESET_PC      (RESET_PC),
        .THREAD_STRIDE (THREAD_STRIDE)
    ) u_pc_file (
        .clk       (clk),
        .rst       (rst),
        .rd_tid    (slot_r),
        .rd_pc     (pc_rd_s),
        .inc_en    (inc_en_s),
        .inc_tid   (slot_r),
        .redir_en  (redir_valid),
        .redir_tid (redir_tid),
        .redir_pc  (redir_pc_s)
    );

    // Slot counter and IF/ID latch; disabled slots still consume their turn but carry a NOP bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r  <= '0;
            if_id_r <= '{valid: 1'b0, tid: '0, pc: '0, instr: INSTR_NOP};
        end else if (!stall) begin
            slot_r  <= slot_r + TW'(1);
            if_id_r <= '{valid: fetch_en_s,
                         tid:   slot_r,
                         pc:    imem_addr,
                         instr: fetch_en_s ? imem_rdata : INSTR_NOP};
        end else begin
            slot_r  <= slot_r;
            if_id_r <= if_id_r;
        end
    end

    assign if_valid = if_id_r.valid;
    assign if_tid   = if_id_r.tid;
    assign if_pc    = if_id_r.pc;
    assign if_instr = if_id_r.instr;

endmodule
